mc_datapath: RTL and testbench
==============================

Name: mc_datapath

Overview:
Parametrised multi-cycle processor datapath with an integrated control FSM and a single unified instruction/data memory port using a req/ack handshake.
- Successor to the single-cycle core: one ALU and one memory port are shared across cycles.
- Supports variable-latency memory.
- Sits between the testbench/top and a unified memory model.

Parameters:
- DATA_W, 32: datapath and register width; must be >= 32.
- ADDR_W, 32: PC and memory address width.
- RF_DEPTH, 32: number of architectural registers; power of 2, <= 32. Register index is inst[25:21]/[20:16]/[15:11] modulo RF_DEPTH.
- RESET_PC, 0: PC value loaded at reset.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: synchronous reset, active-low (asserted when 0).
- mem_req, output, 1: memory access request.
- mem_we, output, 1: 1 = write, 0 = read; valid while mem_req=1.
- mem_adr, output, ADDR_W: access address.
- mem_wdata, output, DATA_W: store data.
- mem_rdata, input, DATA_W: read data; valid in the cycle mem_ack=1.
- mem_ack, input, 1: access complete.
- halted, output, 1: core stopped on a HALT instruction.
- pc_dbg, output, ADDR_W: current PC.
- perf_cycles, output, 32: cycle counter (see Optional Feature).
- perf_retired, output, 32: retired-instruction counter (see Optional Feature).

Behaviour:
- Reset (rst=0 at a clock edge):
  - PC=RESET_PC; all registers=0; IR, A, B, ALUOut, MDR=0.
  - State=FETCH; mem_req=0, mem_we=0, halted=0.
  - Reset mid-access abandons the access; mem_req is low from the next cycle.
  - The first cycle after reset release is FETCH, and mem_req rises in that cycle.
- Handshake:
  - mem_req, mem_we, mem_adr and mem_wdata are held stable until mem_ack is sampled 1.
  - Zero-wait ack (ack in the same cycle as req) is legal.
  - mem_ack while mem_req=0 is ignored.
- States and transitions:
  - FETCH: req read at PC. On ack: IR<=mem_rdata, PC<=PC+4 (mod 2^ADDR_W), go to DECODE.
  - DECODE: A<=RF[rs], B<=RF[rt]; ALUOut<=PC+(sext(imm)<<2). Dispatch on opcode.
  - EXEC_R (op 0x00):
    - funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed): ALUOut<=A op B, go to WB_R.
    - funct 0x08 jr: PC<=A, go to FETCH.
  - EXEC_I:
    - addi 0x08: ALUOut<=A+sext.
    - slti 0x0A: ALUOut<=(A<sext) signed.
    - Go to WB_I.
  - ADDR (lw 0x23 / sw 0x2B): ALUOut<=A+sext, go to MEM_RD or MEM_WR.
  - MEM_RD: req read at ALUOut. On ack: MDR<=rdata, go to WB_MEM.
  - MEM_WR: req write ALUOut<=B. On ack, go to FETCH.
  - BEQ (0x04): if A==B then PC<=ALUOut. Go to FETCH.
  - JUMP (j 0x02 / jal 0x03): PC<={PC[ADDR_W-1:28], imm26, 2'b00}. jal also writes RF[31 mod RF_DEPTH]<=PC (already incremented). Go to FETCH.
  - WB_R: RF[rd]<=ALUOut. WB_I: RF[rt]<=ALUOut. WB_MEM: RF[rt]<=MDR. All return to FETCH.
  - HALT (op 0x3F): halted=1; state is held until reset, with no memory requests.
- Undefined opcode/funct: treated as NOP, return to FETCH, counts as retired.
- Register 0:
  - Reads as 0; writes to it are discarded.
  - RF_DEPTH<32 aliases indices, but index 0 is still zero.
- Arithmetic:
  - Two's complement, wrap-around, no overflow trap.
  - sext extends imm[15:0] to DATA_W.
  - Addresses use ALUOut[ADDR_W-1:0].
- Latency with zero-wait memory:
  - R / addi / slti / sw: 4 cycles.
  - lw: 5 cycles.
  - beq / j / jal / jr: 3 cycles.
  - Each memory wait cycle adds 1 cycle.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- With the macro defined:
  - perf_cycles increments every non-reset cycle while halted=0.
  - perf_retired increments on the final cycle of each instruction.
  - Both counters wrap at 2^32 and reset to 0.
- Without the macro: both ports are tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset, then `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2` with zero-wait memory -> $3=2, pc_dbg=RESET_PC+12 after 12 cycles.
- `sw $1,8($0)` then `lw $4,8($0)`, with mem_ack delayed 3 cycles per access -> mem[8]=5, $4=5; req/adr/we stable through the wait.
- `beq $1,$1,+2` taken and `beq $1,$2,+2` not taken -> PC=branch+12 and PC=branch+4 respectively; each takes 3 cycles.
- `jal 0x40` then `jr $31` -> PC=0x100, $31=jal_addr+4, then PC returns to jal_addr+4; `addi $0,$0,7` leaves $0=0.
- Reset asserted during MEM_RD wait -> mem_req=0 the next cycle, PC=RESET_PC, all registers 0, FETCH after release.
- HALT (0x3F) after 3 instructions -> halted=1, no further mem_req; with MC_PERF_CNT_EN, perf_retired=3 (HALT not counted) and perf_cycles frozen.

Source files
------------

// File: rtl/mc_datapath.sv
// mc_datapath: multi-cycle datapath with an integrated control FSM and one shared
// instruction/data memory port (req/ack handshake, variable latency).
// Optional performance counters are built only when MC_PERF_CNT_EN is defined;
// otherwise perf_cycles/perf_retired are tied to zero.
// ADDR_W must be >= 28 so the jump target field fits.

module mc_datapath #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       RF_DEPTH = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_retired
);

    localparam int unsigned IDX_W = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam logic [IDX_W-1:0] LINK_IDX = IDX_W'(31 % RF_DEPTH);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        StFetch, StDecode, StExecR, StExecI, StAddr, StMemRd, StMemWr,
        StBeq, StJump, StWbR, StWbI, StWbMem, StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, jump_tgt;
    logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
    logic [DATA_W-1:0] rf_q [RF_DEPTH];

    logic              rf_we, retire;
    logic [IDX_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic [5:0]        opcode, funct;
    logic [IDX_W-1:0]  rs_idx, rt_idx, rd_idx;
    logic [DATA_W-1:0] sext_imm, rs_val, rt_val;

    assign opcode   = ir_q[31:26];
    assign funct    = ir_q[5:0];
    assign rs_idx   = ir_q[21 +: IDX_W];
    assign rt_idx   = ir_q[16 +: IDX_W];
    assign rd_idx   = ir_q[11 +: IDX_W];
    assign sext_imm = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    // Index 0 reads zero even when RF_DEPTH < 32 folds other indices onto it.
    assign rs_val   = (rs_idx == '0) ? '0 : rf_q[rs_idx];
    assign rt_val   = (rt_idx == '0) ? '0 : rf_q[rt_idx];

    // Next-state, datapath register updates and register-file write port.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        retire   = 1'b0;
        jump_tgt = pc_q;
        jump_tgt[27:0] = {ir_q[25:0], 2'b00};

        unique case (state_q)
            StFetch: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                a_d   = rs_val;
                b_d   = rt_val;
                alu_d = DATA_W'(pc_q) + (sext_imm << 2);
                case (opcode)
                    OP_R:             state_d = StExecR;
                    OP_ADDI, OP_SLTI: state_d = StExecI;
                    OP_LW, OP_SW:     state_d = StAddr;
                    OP_BEQ:           state_d = StBeq;
                    OP_J, OP_JAL:     state_d = StJump;
                    OP_HALT:          state_d = StHalt;
                    default: begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                endcase
            end
            StExecR: begin
                state_d = StWbR;
                case (funct)
                    FN_ADD:  alu_d = a_q + b_q;
                    FN_SUB:  alu_d = a_q - b_q;
                    FN_AND:  alu_d = a_q & b_q;
                    FN_OR:   alu_d = a_q | b_q;
                    FN_SLT:  alu_d = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                    FN_JR: begin
                        pc_d    = ADDR_W'(a_q);
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d = StFetch;
                        retire  = 1'b1;
                    end
                endcase
            end
            StExecI: begin
                if (opcode == OP_SLTI) begin
                    alu_d = {{(DATA_W-1){1'b0}}, $signed(a_q) < $signed(sext_imm)};
                end else begin
                    alu_d = a_q + sext_imm;
                end
                state_d = StWbI;
            end
            StAddr: begin
                alu_d   = a_q + sext_imm;
                state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                if (mem_ack) begin
                    mdr_d   = mem_rdata;
                    state_d = StWbMem;
                end
            end
            StMemWr: begin
                if (mem_ack) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StBeq: begin
                if (a_q == b_q) pc_d = ADDR_W'(alu_q);
                state_d = StFetch;
                retire  = 1'b1;
            end
            StJump: begin
                pc_d = jump_tgt;
                if (opcode == OP_JAL) begin
                    rf_we    = 1'b1;
                    rf_waddr = LINK_IDX;
                    rf_wdata = DATA_W'(pc_q);
                end
                state_d = StFetch;
                retire  = 1'b1;
            end
            StWbR, StWbI, StWbMem: begin
                rf_we    = 1'b1;
                rf_waddr = (state_q == StWbR) ? rd_idx : rt_idx;
                rf_wdata = (state_q == StWbMem) ? mdr_q : alu_q;
                state_d  = StFetch;
                retire   = 1'b1;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < int'(RF_DEPTH); i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            if (rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // Memory requests are Moore outputs of the state; gating with rst keeps
    // the port idle while reset is held yet lets FETCH request right on release.
    assign mem_req   = rst && ((state_q == StFetch) || (state_q == StMemRd) ||
                               (state_q == StMemWr));
    assign mem_we    = rst && (state_q == StMemWr);
    assign mem_adr   = (state_q == StFetch) ? pc_q : ADDR_W'(alu_q);
    assign mem_wdata = b_q;
    assign halted    = (state_q == StHalt);
    assign pc_dbg    = pc_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_q, cyc_d, ret_q, ret_d;

    // Cycle counter freezes once halted; retire pulses on each instruction's last cycle.
    always_comb begin
        cyc_d = halted ? cyc_q : cyc_q + 32'd1;
        ret_d = retire ? ret_q + 32'd1 : ret_q;
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ret_q <= ret_d;
        end
    end

    assign perf_cycles  = cyc_q;
    assign perf_retired = ret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign perf_cycles   = '0;
    assign perf_retired  = '0;
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: directed programs, bench-owned unified
// memory with programmable ack latency, and a scoreboard of expected stores.

module tb_mc_datapath;

`ifdef MC_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [31:0] HALT = 32'hFC00_0000;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } wr_t;

    logic        clk, rst;
    logic        mem_req, mem_we, mem_ack, halted;
    logic [31:0] mem_adr, mem_wdata, mem_rdata, pc_dbg, perf_cycles, perf_retired;

    logic [31:0] mem [256];
    wr_t         sb_q [$];
    int          wait_cnt  = 0;
    int          ack_delay = 0;
    int          tests     = 0;
    int          fails     = 0;

    assign mem_ack   = mem_req && (wait_cnt == ack_delay);
    assign mem_rdata = mem[mem_adr[9:2]];

    mc_datapath dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_adr      (mem_adr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .halted       (halted),
        .pc_dbg       (pc_dbg),
        .perf_cycles  (perf_cycles),
        .perf_retired (perf_retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(int rs, int rt, int rd, logic [5:0] fn);
        return {OP_R, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(logic [5:0] op, int tgt);
        return {op, 26'(tgt)};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    task automatic push_wr(logic [31:0] adr, logic [31:0] data);
        wr_t ent;
        ent.adr  = adr;
        ent.data = data;
        sb_q.push_back(ent);
    endtask

    // One clock: handshake sampled mid-cycle, memory model and scoreboard updated.
    task automatic step();
        logic        req_s, ack_s;
        logic [31:0] adr_s, wd_s;
        wr_t         ent;
        @(negedge clk);
        req_s = mem_req;
        ack_s = mem_ack;
        adr_s = mem_adr;
        wd_s  = mem_wdata;
        if (req_s && ack_s && mem_we) begin
            mem[adr_s[9:2]] = wd_s;
            tests++;
            assert (sb_q.size() != 0) else begin
                fails++;
                $error("FAIL sb_unexpected_write: observed adr %0h data %0h required none",
                       adr_s, wd_s);
            end
            if (sb_q.size() != 0) begin
                ent = sb_q.pop_front();
                check("sb_adr", adr_s, ent.adr);
                check("sb_data", wd_s, ent.data);
            end
        end
        @(posedge clk);
        #1;
        wait_cnt = (req_s && !ack_s) ? wait_cnt + 1 : 0;
    endtask

    task automatic hold_reset();
        rst = 1'b0;
        step();
        step();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        sb_q.delete();
    endtask

    task automatic run_to_halt(string tag, int max_cycles);
        for (int i = 0; i < max_cycles && !halted; i++) step();
        check(tag, halted, 1);
    endtask

    task automatic check_perf(string tag, int cyc, int ret);
        check({tag, "_perf_cyc"}, perf_cycles, PerfEn ? cyc : 0);
        check({tag, "_perf_ret"}, perf_retired, PerfEn ? ret : 0);
    endtask

    initial begin
        int req_seen;
        rst = 1'b0;

        // ---- Test 1: ALU ops, zero-wait memory, exact timing, halt behaviour
        ack_delay = 0;
        hold_reset();
        check("rst_req", mem_req, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc_dbg, 0);
        check_perf("rst", 0, 0);
        mem[0]  = enc_i(OP_ADDI, 0, 1, 5);
        mem[1]  = enc_i(OP_ADDI, 0, 2, -3);
        mem[2]  = enc_r(1, 2, 3, 6'h20);
        mem[3]  = enc_i(OP_SW, 0, 3, 'h80);
        mem[4]  = enc_i(OP_SW, 0, 2, 'h84);
        mem[5]  = enc_i(OP_SLTI, 2, 5, 0);
        mem[6]  = enc_r(1, 2, 6, 6'h22);
        mem[7]  = enc_r(1, 2, 7, 6'h24);
        mem[8]  = enc_r(1, 2, 8, 6'h25);
        mem[9]  = enc_r(2, 1, 9, 6'h2A);
        mem[10] = enc_i(OP_SW, 0, 5, 'h88);
        mem[11] = enc_i(OP_SW, 0, 6, 'h8C);
        mem[12] = enc_i(OP_SW, 0, 7, 'h90);
        mem[13] = enc_i(OP_SW, 0, 8, 'h94);
        mem[14] = enc_i(OP_SW, 0, 9, 'h98);
        mem[15] = HALT;
        push_wr(32'h80, 32'd2);
        push_wr(32'h84, 32'hFFFF_FFFD);
        push_wr(32'h88, 32'd1);
        push_wr(32'h8C, 32'd8);
        push_wr(32'h90, 32'd5);
        push_wr(32'h94, 32'hFFFF_FFFD);
        push_wr(32'h98, 32'd1);
        rst = 1'b1;
        #1;
        check("t1_first_fetch", {mem_req, mem_we, mem_adr}, {1'b1, 1'b0, 32'h0});
        repeat (11) step();
        check("t1_c11_wb_no_req", mem_req, 0);
        step();
        check("t1_c12_fetch", {mem_req, mem_adr}, {1'b1, 32'd12});
        check("t1_c12_pc", pc_dbg, 12);
        run_to_halt("t1_halt", 200);
        check("t1_halt_pc", pc_dbg, 64);
        check_perf("t1", 62, 15);
        req_seen = 0;
        repeat (10) begin
            step();
            if (mem_req) req_seen++;
        end
        check("t1_no_req_when_halted", req_seen, 0);
        check_perf("t1_frozen", 62, 15);
        check("t1_sb_empty", sb_q.size(), 0);

        // ---- Test 2: sw/lw with three wait cycles per access
        ack_delay = 3;
        hold_reset();
        mem[0] = enc_i(OP_ADDI, 0, 1, 5);
        mem[1] = enc_i(OP_SW, 0, 1, 'h180);
        mem[2] = enc_i(OP_LW, 0, 4, 'h180);
        mem[3] = enc_i(OP_SW, 0, 4, 'h184);
        mem[4] = HALT;
        push_wr(32'h180, 32'd5);
        push_wr(32'h184, 32'd5);
        rst = 1'b1;
        repeat (13) step();
        for (int k = 0; k < 4; k++) begin
            check("t2_sw_hold_ctl", {mem_req, mem_we, mem_adr}, {1'b1, 1'b1, 32'h180});
            check("t2_sw_hold_wdata", mem_wdata, 5);
            step();
        end
        check("t2_after_sw_fetch", {mem_req, mem_we, mem_adr}, {1'b1, 1'b0, 32'd8});
        run_to_halt("t2_halt", 200);
        check("t2_halt_pc", pc_dbg, 20);
        check_perf("t2", 43, 4);
        check("t2_sb_empty", sb_q.size(), 0);

        // ---- Test 3: beq taken / not taken, 3 cycles each
        ack_delay = 0;
        hold_reset();
        mem[0] = enc_i(OP_ADDI, 0, 1, 1);
        mem[1] = enc_i(OP_ADDI, 0, 2, 2);
        mem[2] = enc_i(OP_BEQ, 1, 1, 2);
        mem[3] = enc_i(OP_SW, 0, 1, 'h100);
        mem[4] = enc_i(OP_SW, 0, 1, 'h104);
        mem[5] = enc_i(OP_BEQ, 1, 2, 2);
        mem[6] = enc_i(OP_SW, 0, 2, 'h108);
        mem[7] = HALT;
        push_wr(32'h108, 32'd2);
        rst = 1'b1;
        repeat (10) step();
        check("t3_beq_state_no_req", mem_req, 0);
        step();
        check("t3_taken_fetch", {mem_req, mem_adr}, {1'b1, 32'd20});
        check("t3_taken_pc", pc_dbg, 20);
        repeat (3) step();
        check("t3_not_taken_fetch", {mem_req, mem_adr}, {1'b1, 32'd24});
        run_to_halt("t3_halt", 200);
        check("t3_halt_pc", pc_dbg, 32);
        check_perf("t3", 20, 5);
        check("t3_sb_empty", sb_q.size(), 0);

        // ---- Test 4: jal / jr and writes to $0 discarded
        hold_reset();
        mem[0]      = enc_i(OP_ADDI, 0, 0, 7);
        mem[1]      = enc_j(OP_JAL, 'h40);
        mem[2]      = HALT;
        mem['h40]   = enc_i(OP_SW, 0, 31, 'h180);
        mem['h41]   = enc_i(OP_SW, 0, 0, 'h184);
        mem['h42]   = enc_r(31, 0, 0, 6'h08);
        push_wr(32'h180, 32'd8);
        push_wr(32'h184, 32'd0);
        rst = 1'b1;
        repeat (7) step();
        check("t4_jal_target", {mem_req, mem_adr}, {1'b1, 32'h100});
        repeat (11) step();
        check("t4_jr_return", {mem_req, mem_adr}, {1'b1, 32'd8});
        run_to_halt("t4_halt", 200);
        check("t4_halt_pc", pc_dbg, 12);
        check_perf("t4", 20, 5);
        check("t4_sb_empty", sb_q.size(), 0);

        // ---- Test 5: reset during a MEM_RD wait
        ack_delay = 3;
        hold_reset();
        mem[0]    = enc_i(OP_ADDI, 0, 1, 9);
        mem[1]    = enc_i(OP_LW, 0, 2, 'h180);
        mem['h60] = 32'h1234;
        rst = 1'b1;
        repeat (14) step();
        check("t5_in_mem_rd", {mem_req, mem_we, mem_adr}, {1'b1, 1'b0, 32'h180});
        rst = 1'b0;
        step();
        check("t5_rst_req_low", mem_req, 0);
        check("t5_rst_pc", pc_dbg, 0);
        check("t5_rst_halted", halted, 0);
        check_perf("t5_rst", 0, 0);
        mem[0] = enc_i(OP_SW, 0, 1, 'h184);
        mem[1] = enc_i(OP_SW, 0, 2, 'h188);
        mem[2] = HALT;
        push_wr(32'h184, 32'd0);
        push_wr(32'h188, 32'd0);
        rst = 1'b1;
        #1;
        check("t5_release_fetch", {mem_req, mem_we, mem_adr}, {1'b1, 1'b0, 32'h0});
        run_to_halt("t5_halt", 200);
        check("t5_halt_pc", pc_dbg, 12);
        check_perf("t5", 25, 2);
        check("t5_sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
